cam_param: RTL
==============

// Module: cam_param
// PURPOSE
//   Parametrised content-addressable memory with per-entry valid bits. Supports
//   lookup, duplicate-free insert into the lowest free slot, delete-by-key and a
//   multi-cycle flush. Results are registered with one-cycle latency.
//   Sits beside the datapath as a key-to-index translator.
// PARAMETERS
//   DATA_W  8   key width in bits (>=1)
//   DEPTH   16  number of entries (>=2)
//   ADDR_W  $clog2(DEPTH)  index width (derived; do not override)
// PORTS
//   clk        in   1       single clock, rising edge
//   rst        in   1       synchronous reset, active-high
//   op_valid   in   1       operation request
//   op_ready   out  1       block can accept an op (1 in IDLE, 0 in FLUSH)
//   op         in   2       00 LOOKUP, 01 INSERT, 10 DELETE, 11 FLUSH
//   key        in   DATA_W  search / insert / delete key (ignored for FLUSH)
//   res_valid  out  1       one-cycle pulse: result fields valid
//   res_hit    out  1       key found in a valid entry
//   res_addr   out  ADDR_W  matching or written index
//   res_err    out  1       INSERT refused: table full, key absent
//   count      out  ADDR_W+1  number of valid entries
//   full       out  1       count == DEPTH (combinational from count)
//   empty      out  1       count == 0 (combinational from count)
// BEHAVIOUR
//   Reset (rst=1 at posedge): all valid bits 0, state IDLE, res_* = 0, count = 0.
//     Key storage is not cleared. Reset wins over any op, including mid-FLUSH.
//   Accept: op accepted when op_valid && op_ready at a posedge (cycle N).
//     Table and count update at that edge. res_* are valid in cycle N+1 and
//     res_valid is high for exactly one cycle. Back-to-back ops are allowed.
//     An op accepted in N+1 sees the updates made by the op accepted in N.
//   Match: entry i matches iff valid[i] && mem[i]==key. Priority is to the
//     lowest matching index. Insert never creates duplicates, so at most one
//     entry can match.
//   LOOKUP: res_hit = any match; res_addr = match index, else 0. No state change.
//   INSERT:
//     - key present: res_hit=1, res_addr=existing index, no write, count unchanged.
//     - else free slot: write lowest invalid index i (mem[i]=key, valid[i]=1),
//       count+1, res_hit=0, res_addr=i.
//     - else (full): res_err=1, res_hit=0, res_addr=0, no change.
//   DELETE:
//     - hit: valid[i]=0, count-1, res_hit=1, res_addr=i.
//     - miss: res_hit=0, res_addr=0, no change.
//   res_err is 0 for every op except a refused INSERT.
//   FSM: IDLE -> FLUSH on accepted FLUSH op; ptr=0, op_ready=0.
//     - FLUSH: each cycle clear valid[ptr]; decrement count if it was set; ptr+1.
//     - When ptr==DEPTH-1 is cleared: go to IDLE; res_valid=1, res_hit=0,
//       res_addr=DEPTH-1.
//     - FLUSH takes exactly DEPTH cycles after acceptance; op_ready returns
//       high in the cycle after the last clear.
//     - op_valid is ignored while op_ready=0; no op is queued.
//   Widths: count saturates naturally at 0..DEPTH; it never wraps under legal
//     ops. ptr is ADDR_W bits wide. Results are stable until the next res_valid.
// TESTING
//   1. Reset, then LOOKUP 0x00 -> res_hit=0 (valid bits cleared, not data); count=0, empty=1.
//   2. INSERT 0xA5, 0x3C, 0xA5 back-to-back -> addr 0 hit=0, addr 1 hit=0,
//      addr 0 hit=1; count=2.
//   3. Fill all DEPTH=16 slots, then INSERT a new key -> res_err=1, full=1;
//      then INSERT an existing key -> res_hit=1, res_err=0.
//   4. DELETE key at idx 5, then INSERT a new key -> written at idx 5;
//      DELETE an absent key -> hit=0, count unchanged.
//   5. FLUSH with 16 valid entries -> op_ready=0 for 16 cycles, count steps
//      16..0, res_valid with res_addr=15; op_valid during FLUSH is ignored.
//   6. rst asserted mid-FLUSH at ptr=7 -> next cycle IDLE, op_ready=1,
//      count=0, all lookups miss.

Source files
------------

// File: rtl/cam_param_if.sv
// cam_param_if: operation request and result bundle for cam_param
interface cam_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int ADDR_W = $clog2(DEPTH);
    logic              op_valid;
    logic              op_ready;
    logic [1:0]        op;
    logic [DATA_W-1:0] key;
    logic              res_valid;
    logic              res_hit;
    logic [ADDR_W-1:0] res_addr;
    logic              res_err;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              empty;
    modport master (
        output op_valid, op, key,
        input  op_ready, res_valid, res_hit, res_addr, res_err, count, full, empty
    );
    modport slave (
        input  op_valid, op, key,
        output op_ready, res_valid, res_hit, res_addr, res_err, count, full, empty
    );
endinterface

// File: rtl/cam_param.sv
// cam_param: valid-tagged CAM with lookup, lowest-free insert, delete and multi-cycle flush
module cam_param #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input logic       clk,
    input logic       rst,
    cam_param_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_FLUSH  = 2'b11;
    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH-1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t            state, state_n;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   cnt;
    logic              hit, free;
    logic [ADDR_W-1:0] hit_idx, free_idx;
    logic              accept, last, wr_en, ready;
    logic              res_valid, res_hit, res_err;
    logic [ADDR_W-1:0] res_addr;

    // descending scan so the lowest matching / free index is the one left standing
    always_comb begin
        hit      = 1'b0;
        hit_idx  = '0;
        free     = 1'b0;
        free_idx = '0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (valid[i] && mem[i] == bus.key) begin
                hit     = 1'b1;
                hit_idx = ADDR_W'(i);
            end
            if (!valid[i]) begin
                free     = 1'b1;
                free_idx = ADDR_W'(i);
            end
        end
    end

    always_comb begin
        ready   = state == IDLE;
        accept  = bus.op_valid && ready;
        last    = state == FLUSH && ptr == PTR_LAST;
        wr_en   = accept && bus.op == OP_INSERT && !hit && free;
        state_n = state == IDLE ? ((accept && bus.op == OP_FLUSH) ? FLUSH : IDLE)
                                : (last ? IDLE : FLUSH);
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[free_idx] <= bus.key;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= '0;
            cnt       <= '0;
            ptr       <= '0;
            res_valid <= 1'b0;
            res_hit   <= 1'b0;
            res_addr  <= '0;
            res_err   <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (state == FLUSH) begin
                valid[ptr] <= 1'b0;
                if (valid[ptr])
                    cnt <= cnt - CNT_ONE;
                ptr <= ptr + PTR_ONE;
                if (last) begin
                    res_valid <= 1'b1;
                    res_hit   <= 1'b0;
                    res_addr  <= PTR_LAST;
                    res_err   <= 1'b0;
                end
            end else if (accept) begin
                unique case (bus.op)
                    OP_LOOKUP: begin
                        res_valid <= 1'b1;
                        res_hit   <= hit;
                        res_addr  <= hit ? hit_idx : '0;
                        res_err   <= 1'b0;
                    end
                    OP_INSERT: begin
                        res_valid <= 1'b1;
                        res_hit   <= hit;
                        res_addr  <= hit ? hit_idx : (free ? free_idx : '0);
                        res_err   <= !hit && !free;
                        if (wr_en) begin
                            valid[free_idx] <= 1'b1;
                            cnt             <= cnt + CNT_ONE;
                        end
                    end
                    OP_DELETE: begin
                        res_valid <= 1'b1;
                        res_hit   <= hit;
                        res_addr  <= hit ? hit_idx : '0;
                        res_err   <= 1'b0;
                        if (hit) begin
                            valid[hit_idx] <= 1'b0;
                            cnt            <= cnt - CNT_ONE;
                        end
                    end
                    OP_FLUSH: ptr <= '0;
                endcase
            end
        end
    end

    assign bus.op_ready  = ready;
    assign bus.res_valid = res_valid;
    assign bus.res_hit   = res_hit;
    assign bus.res_addr  = res_addr;
    assign bus.res_err   = res_err;
    assign bus.count     = cnt;
    assign bus.full      = cnt == (ADDR_W+1)'(DEPTH);
    assign bus.empty     = cnt == '0;
endmodule
